// File: rtl/addsub_16bit_serial_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
package addsub_16bit_serial_pkg;

  // Width of one serial digit; the datapath handles one of these per cycle.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_16bit_serial_nibble_add.sv
// Combinational 4-bit adder slice. c3 (carry into bit 3) is exported so
// the top can form signed overflow from the final slice.
module nibble_add
  import addsub_16bit_serial_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W-1:0] low;
  logic [1:0]       top;

  // Ripple through the low three bits, then finish the MSB separately to expose c3
  always_comb begin
    low  = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};
    c3   = low[NIB_W-1];
    top  = {1'b0, a[NIB_W-1]} + {1'b0, b[NIB_W-1]} + {1'b0, c3};
    s    = {top[0], low[NIB_W-2:0]};
    cout = top[1];
  end

endmodule

// File: rtl/addsub_16bit_serial.sv
// Nibble-serial two's complement adder/subtractor, LSB nibble first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; result outputs hold last values
// ST_RUN  | one nibble per cycle, counter cnt = 0..NIB-1
// ST_DONE | done pulse cycle; start here begins the next op directly
module addsub_16bit_serial
  import addsub_16bit_serial_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NIB_W*NIB-1:0] a,
  input  logic [NIB_W*NIB-1:0] b,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [NIB_W*NIB-1:0] sum,
  output logic                 ovfl,
  output logic                 cout
);

  localparam int W  = NIB_W * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic [W-1:0]    sum_q;
  logic            busy_q;
  logic            done_q;
  logic            ovfl_q;
  logic            cout_q;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_co;
  logic             nib_c3;

  // Select the current nibble; subtraction is A + ~B + 1 with the +1 from the seeded carry
  always_comb begin
    nib_a = a_q[NIB_W*cnt +: NIB_W];
    nib_b = sub_q ? ~b_q[NIB_W*cnt +: NIB_W] : b_q[NIB_W*cnt +: NIB_W];
  end

  nibble_add u_nibble_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_co),
    .c3   (nib_c3)
  );

  // Sequencer and datapath registers; reset has priority over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sum_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovfl_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            carry  <= sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q[NIB_W*cnt +: NIB_W] <= nib_s;
          carry <= nib_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIB - 1)) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cout_q <= nib_co;
            ovfl_q <= nib_c3 ^ nib_co;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign ovfl = ovfl_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_addsub_16bit_serial.sv
// Directed and random checks for the nibble-serial adder/subtractor.
module tb_addsub_16bit_serial;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         ovfl;
  logic         cout;

  int n_cmp;
  int n_err;

  addsub_16bit_serial #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .ovfl  (ovfl),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op at a negedge, scramble inputs while it runs, and return
  // the number of edges from the start-sampling edge to the one raising done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       output int lat);
    int n;
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
    chk("busy_run", {31'd0, busy}, 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n - 1;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] ra, rb, bb, exp_s;
    logic         rs, exp_c, exp_v;
    logic [W:0]   full;

    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {16'd0, sum},  32'd0);
    chk("rst_ovfl", {31'd0, ovfl}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x7FFF + 1 overflows positive to negative
    do_op(16'h7FFF, 16'h0001, 1'b0, lat);
    chk("ovp_lat",  lat, 32'd4);
    chk("ovp_sum",  {16'd0, sum},  32'h8000);
    chk("ovp_ovfl", {31'd0, ovfl}, 32'd1);
    chk("ovp_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    chk("done_pulse_len", {31'd0, done}, 32'd0);
    chk("hold_sum_idle",  {16'd0, sum},  32'h8000);

    do_op(16'h8000, 16'h0001, 1'b1, lat);
    chk("ovn_sum",  {16'd0, sum},  32'h7FFF);
    chk("ovn_ovfl", {31'd0, ovfl}, 32'd1);
    chk("ovn_cout", {31'd0, cout}, 32'd1);
    @(negedge clk);

    do_op(16'h0000, 16'h0001, 1'b1, lat);
    chk("brw_sum",  {16'd0, sum},  32'hFFFF);
    chk("brw_ovfl", {31'd0, ovfl}, 32'd0);
    chk("brw_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);

    // Second start while busy must be ignored
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        pulses++;
        chk("ign_sum", {16'd0, sum}, 32'h5555);
      end
      @(negedge clk);
    end
    chk("ign_pulses", pulses, 32'd1);
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: start held during the DONE cycle
    do_op(16'h0001, 16'h0002, 1'b0, lat);
    chk("b2b_first_sum", {16'd0, sum}, 32'h0003);
    a = 16'h0F0F; b = 16'h00F1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_gap",  lat, 32'd5);
    chk("b2b_sum",  {16'd0, sum},  32'h1000);
    chk("b2b_ovfl", {31'd0, ovfl}, 32'd0);
    @(negedge clk);

    // Reset two cycles into an operation discards it
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sum",  {16'd0, sum},  32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", pulses, 32'd0);

    // start coinciding with rst is ignored
    rst = 1'b1; start = 1'b1; a = 16'h0005; b = 16'h0005;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rst_start_idle", {31'd0, busy}, 32'd0);

    do_op(16'h0003, 16'h0005, 1'b1, lat);
    chk("post_rst_sum",  {16'd0, sum},  32'hFFFE);
    chk("post_rst_ovfl", {31'd0, ovfl}, 32'd0);
    chk("post_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      full  = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, rs};
      exp_s = full[W-1:0];
      exp_c = full[W];
      exp_v = (ra[W-1] == bb[W-1]) && (exp_s[W-1] != ra[W-1]);
      do_op(ra, rb, rs, lat);
      chk("rnd_sum",  {16'd0, sum},  {16'd0, exp_s});
      chk("rnd_cout", {31'd0, cout}, {31'd0, exp_c});
      chk("rnd_ovfl", {31'd0, ovfl}, {31'd0, exp_v});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
